// File: rtl/psi_pkg.sv
// ============================================================================
// psi_pkg : shared types and sizing helpers for the serializer family
// Revision: 1.0
// ============================================================================
`default_nettype none

package psi_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_STALL = 2'd2,
        S_GAP   = 2'd3
    } state_t;

    localparam int GAP_CW = 4;

    function automatic int calc_beats(input int dsize, input int lanes);
        return dsize / lanes;
    endfunction

    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // The packet-end flag sits just above the payload in every FIFO word.
    function automatic int pkt_end_bit(input int dsize);
        return dsize;
    endfunction

endpackage

`default_nettype wire

// File: rtl/multi_serial_com_lane_shifter.sv
// ============================================================================
// lane_shifter : word shift register, chunk select and beat counter
// Revision: 1.0
// ============================================================================
`default_nettype none

module lane_shifter
    import psi_pkg::*;
#(
    parameter int DSIZE     = 32,
    parameter int LANES     = 1,
    parameter int MSB_FIRST = 1,
    parameter int BEATS     = calc_beats(DSIZE, LANES),
    parameter int BW        = cnt_width(BEATS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             shift,
    input  logic [DSIZE-1:0] data,
    output logic [LANES-1:0] chunk,
    output logic [BW-1:0]    beat,
    output logic             last,
    output logic             next_last
);

    logic [DSIZE-1:0] sreg;
    logic [DSIZE-1:0] sreg_shifted;
    logic [LANES-1:0] head_load;
    logic [LANES-1:0] head_shift;

    generate
        if (MSB_FIRST != 0) begin : g_msb
            assign sreg_shifted = sreg << LANES;
            assign head_load    = data[DSIZE-1 -: LANES];
            assign head_shift   = sreg_shifted[DSIZE-1 -: LANES];
        end else begin : g_lsb
            assign sreg_shifted = sreg >> LANES;
            assign head_load    = data[LANES-1:0];
            assign head_shift   = sreg_shifted[LANES-1:0];
        end
    endgenerate

    assign last      = (int'(beat) == BEATS - 1);
    assign next_last = (int'(beat) == BEATS - 2);

    // Chunk register returns to zero whenever neither loading nor shifting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg  <= '0;
            chunk <= '0;
            beat  <= '0;
        end else if (load) begin
            sreg  <= data;
            chunk <= head_load;
            beat  <= '0;
        end else if (shift) begin
            sreg  <= sreg_shifted;
            chunk <= head_shift;
            beat  <= beat + 1'b1;
        end else begin
            chunk <= '0;
        end
    end

endmodule

`default_nettype wire

// File: rtl/multi_serial_com.sv
// ============================================================================
// multi_serial_com : FIFO-fed multi-lane serializer with packet framing
// Revision: 1.0
// ============================================================================
`default_nettype none

module multi_serial_com
    import psi_pkg::*;
#(
    parameter int DSIZE     = 32,
    parameter int LANES     = 1,
    parameter int MSB_FIRST = 1,
    parameter int GAP       = 2
) (
    input  logic             s_clk,
    input  logic             n_rst,
    input  logic [DSIZE:0]   rdata,
    input  logic             rempty,
    output logic             r_en,
    output logic [LANES-1:0] s_out,
    output logic             s_valid,
    output logic             s_sop,
    output logic             s_eop,
    output logic             underrun
);

    localparam int BEATS   = calc_beats(DSIZE, LANES);
    localparam int BW      = cnt_width(BEATS);
    localparam int PKT_END = pkt_end_bit(DSIZE);

    state_t              state, state_nx;
    logic                cur_end, cur_end_nx;
    logic                in_pkt, in_pkt_nx;
    logic [GAP_CW-1:0]   gap_cnt, gap_cnt_nx;
    logic                valid_nx, sop_nx, eop_nx, underrun_nx;
    logic                load, shift;
    logic [BW-1:0]       beat;
    logic                last, next_last;

    lane_shifter #(
        .DSIZE     (DSIZE),
        .LANES     (LANES),
        .MSB_FIRST (MSB_FIRST)
    ) u_shifter (
        .clk       (s_clk),
        .rst_n     (n_rst),
        .load      (load),
        .shift     (shift),
        .data      (rdata[DSIZE-1:0]),
        .chunk     (s_out),
        .beat      (beat),
        .last      (last),
        .next_last (next_last)
    );

    always_ff @(posedge s_clk or negedge n_rst) begin
        if (!n_rst) begin
            state    <= S_IDLE;
            cur_end  <= 1'b0;
            in_pkt   <= 1'b0;
            gap_cnt  <= '0;
            s_valid  <= 1'b0;
            s_sop    <= 1'b0;
            s_eop    <= 1'b0;
            underrun <= 1'b0;
        end else begin
            state    <= state_nx;
            cur_end  <= cur_end_nx;
            in_pkt   <= in_pkt_nx;
            gap_cnt  <= gap_cnt_nx;
            s_valid  <= valid_nx;
            s_sop    <= sop_nx;
            s_eop    <= eop_nx;
            underrun <= underrun_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        cur_end_nx  = cur_end;
        in_pkt_nx   = in_pkt;
        gap_cnt_nx  = gap_cnt;
        valid_nx    = 1'b0;
        sop_nx      = 1'b0;
        eop_nx      = 1'b0;
        underrun_nx = 1'b0;
        r_en        = 1'b0;
        load        = 1'b0;
        shift       = 1'b0;

        case (state)
            S_IDLE: begin
                r_en = !rempty;
            end
            S_SHIFT: begin
                if (!last) begin
                    shift    = 1'b1;
                    valid_nx = 1'b1;
                    eop_nx   = next_last && cur_end;
                end else if (cur_end) begin
                    in_pkt_nx = 1'b0;
                    if (GAP > 0) begin
                        state_nx   = S_GAP;
                        gap_cnt_nx = GAP_CW'(GAP - 1);
                    end else begin
                        state_nx = S_IDLE;
                        r_en     = !rempty;
                    end
                end else begin
                    r_en = !rempty;
                    if (rempty) begin
                        state_nx    = S_STALL;
                        underrun_nx = 1'b1;
                    end
                end
            end
            S_STALL: begin
                r_en = !rempty;
            end
            S_GAP: begin
                if (gap_cnt == '0) begin
                    state_nx = S_IDLE;
                end else begin
                    gap_cnt_nx = gap_cnt - 1'b1;
                end
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase

        // A pop always loads the next word; it opens a packet only when none is in flight.
        if (r_en) begin
            load       = 1'b1;
            state_nx   = S_SHIFT;
            valid_nx   = 1'b1;
            cur_end_nx = rdata[PKT_END];
            sop_nx     = !in_pkt_nx;
            in_pkt_nx  = 1'b1;
            eop_nx     = (BEATS == 1) && rdata[PKT_END];
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_multi_serial_com.sv
// ============================================================================
// tb_multi_serial_com : scoreboard bench over three serializer configurations
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_multi_serial_com;

    logic clk = 1'b0;
    logic n_rst = 1'b0;
    always #5 clk = ~clk;

    // Instance 0: MSB-first, 2 lanes, GAP 2. Instance 1: LSB-first. Instance 2: 8 lanes, GAP 0.
    logic [8:0] rdata0 = '0, rdata1 = '0, rdata2 = '0;
    logic       rempty0 = 1'b1, rempty1 = 1'b1, rempty2 = 1'b1;
    logic       ren0, ren1, ren2;
    logic [1:0] out0, out1;
    logic [7:0] out2;
    logic       val0, val1, val2, sop0, sop1, sop2, eop0, eop1, eop2;
    logic       und0, und1, und2;

    multi_serial_com #(.DSIZE(8), .LANES(2), .MSB_FIRST(1), .GAP(2)) u_dut0 (
        .s_clk(clk), .n_rst(n_rst), .rdata(rdata0), .rempty(rempty0), .r_en(ren0),
        .s_out(out0), .s_valid(val0), .s_sop(sop0), .s_eop(eop0), .underrun(und0));
    multi_serial_com #(.DSIZE(8), .LANES(2), .MSB_FIRST(0), .GAP(2)) u_dut1 (
        .s_clk(clk), .n_rst(n_rst), .rdata(rdata1), .rempty(rempty1), .r_en(ren1),
        .s_out(out1), .s_valid(val1), .s_sop(sop1), .s_eop(eop1), .underrun(und1));
    multi_serial_com #(.DSIZE(8), .LANES(8), .MSB_FIRST(1), .GAP(0)) u_dut2 (
        .s_clk(clk), .n_rst(n_rst), .rdata(rdata2), .rempty(rempty2), .r_en(ren2),
        .s_out(out2), .s_valid(val2), .s_sop(sop2), .s_eop(eop2), .underrun(und2));

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int und_cnt [3];

    logic [8:0] fq0 [$], fq1 [$], fq2 [$];
    logic [9:0] eq0 [$], eq1 [$], eq2 [$];
    int         rq0 [$], rq1 [$], rq2 [$];

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    // FIFO models: pop on the DUT's r_en edge, present the new head shortly after.
    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            fq0.delete(); fq1.delete(); fq2.delete();
        end else begin
            if (ren0 && fq0.size() > 0) void'(fq0.pop_front());
            if (ren1 && fq1.size() > 0) void'(fq1.pop_front());
            if (ren2 && fq2.size() > 0) void'(fq2.pop_front());
        end
        #1;
        rempty0 = (fq0.size() == 0); rdata0 = (fq0.size() > 0) ? fq0[0] : 9'h0;
        rempty1 = (fq1.size() == 0); rdata1 = (fq1.size() > 0) ? fq1[0] : 9'h0;
        rempty2 = (fq2.size() == 0); rdata2 = (fq2.size() > 0) ? fq2[0] : 9'h0;
    end

    always @(posedge clk) cyc++;

    // Push a word to a FIFO model and its expected beats {sop, eop, chunk} to the scoreboard.
    task automatic push_word(input int k, input logic [8:0] w, input bit first);
        int         lanes;
        int         nb;
        bit         msb;
        logic [7:0] mask;
        logic [7:0] d;
        logic [7:0] ch;
        lanes = (k == 2) ? 8 : 2;
        msb   = (k != 1);
        nb    = 8 / lanes;
        mask  = 8'((1 << lanes) - 1);
        d     = w[7:0];
        for (int i = 0; i < nb; i++) begin
            if (msb) ch = (d >> (8 - (i + 1) * lanes)) & mask;
            else     ch = (d >> (i * lanes)) & mask;
            case (k)
                0: eq0.push_back({first && (i == 0), w[8] && (i == nb - 1), ch});
                1: eq1.push_back({first && (i == 0), w[8] && (i == nb - 1), ch});
                default: eq2.push_back({first && (i == 0), w[8] && (i == nb - 1), ch});
            endcase
        end
        case (k)
            0: fq0.push_back(w);
            1: fq1.push_back(w);
            default: fq2.push_back(w);
        endcase
    endtask

    task automatic mon(input int k, input logic v, input logic sp, input logic ep,
                       input logic [7:0] o, input logic re, input logic em, input logic un);
        logic [9:0] exp;
        if (re) begin
            case (k)
                0: rq0.push_back(cyc);
                1: rq1.push_back(cyc);
                default: rq2.push_back(cyc);
            endcase
        end
        if (un) und_cnt[k]++;
        check_value($sformatf("ren_while_empty%0d", k), {31'd0, re && em}, 32'd0);
        if (v) begin
            exp = 10'h3FF;
            case (k)
                0: if (eq0.size() > 0) exp = eq0.pop_front();
                1: if (eq1.size() > 0) exp = eq1.pop_front();
                default: if (eq2.size() > 0) exp = eq2.pop_front();
            endcase
            check_value($sformatf("beat%0d{sop,eop,out}", k), {22'd0, sp, ep, o}, {22'd0, exp});
        end else begin
            check_value($sformatf("idle%0d{sop,eop,out}", k), {22'd0, sp, ep, o}, 32'd0);
        end
    endtask

    always @(negedge clk) begin
        if (n_rst) begin
            mon(0, val0, sop0, eop0, {6'd0, out0}, ren0, rempty0, und0);
            mon(1, val1, sop1, eop1, {6'd0, out1}, ren1, rempty1, und1);
            mon(2, val2, sop2, eop2, out2, ren2, rempty2, und2);
        end
    end

    task automatic drain();
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #2;
            if (fq0.size() + fq1.size() + fq2.size() + eq0.size() + eq1.size() + eq2.size() == 0)
                break;
        end
        check_value("drain_left", fq0.size() + fq1.size() + fq2.size()
                    + eq0.size() + eq1.size() + eq2.size(), 0);
        repeat (8) @(posedge clk);
        #2;
    endtask

    initial begin
        und_cnt = '{0, 0, 0};
        repeat (3) @(posedge clk);
        #2;
        check_value("reset_outs0", {und0, val0, sop0, eop0, out0, ren0}, 0);
        check_value("reset_outs1", {und1, val1, sop1, eop1, out1, ren1}, 0);
        check_value("reset_outs2", {und2, val2, sop2, eop2, out2, ren2}, 0);
        n_rst = 1'b1;
        repeat (2) @(posedge clk);
        #2;

        // Two single-word packets: r_en spacing is BEATS + GAP + 1.
        rq0.delete();
        push_word(0, 9'h1B4, 1);
        push_word(0, 9'h1B4, 1);
        drain();
        check_value("gap_pops", rq0.size(), 2);
        if (rq0.size() == 2) check_value("gap_spacing", rq0[1] - rq0[0], 7);

        push_word(1, 9'h1B4, 1);
        drain();

        // Two-word packet: second pop on the last beat of the first word.
        rq0.delete();
        push_word(0, 9'h0A5, 1);
        push_word(0, 9'h13C, 0);
        drain();
        check_value("cont_pops", rq0.size(), 2);
        if (rq0.size() == 2) check_value("cont_spacing", rq0[1] - rq0[0], 4);

        // Underrun mid-packet, then resume.
        check_value("und_before", und_cnt[0], 0);
        push_word(0, 9'h0FF, 1);
        repeat (10) @(posedge clk);
        #2;
        check_value("und_pulses", und_cnt[0], 1);
        check_value("stall_beats_left", eq0.size(), 0);
        push_word(0, 9'h100, 0);
        drain();
        check_value("und_after", und_cnt[0], 1);

        // GAP=0, full-width lanes: back-to-back single-beat packets.
        rq2.delete();
        push_word(2, 9'h111, 1);
        push_word(2, 9'h122, 1);
        drain();
        check_value("b2b_pops", rq2.size(), 2);
        if (rq2.size() == 2) check_value("b2b_spacing", rq2[1] - rq2[0], 1);
        check_value("und_others", und_cnt[1] + und_cnt[2], 0);

        // Asynchronous reset during beat 1 of a word.
        push_word(0, 9'h1B4, 1);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #2;
            if (val0 && sop0) break;
        end
        @(posedge clk); #2;
        check_value("pre_reset_beat1", {val0, out0}, {29'd0, 1'b1, 2'd3});
        n_rst = 1'b0;
        #1;
        check_value("async_reset_outs", {und0, val0, sop0, eop0, out0}, 0);
        eq0.delete();
        @(posedge clk); #2;
        n_rst = 1'b1;
        push_word(0, 9'h1C3, 1);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, got running expected done");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
